e_mdu: RTL and testbench

//   Execute-stage multiply/divide unit beside the ALU. Consumes the same forwarded E-stage operands.

---
 rtl/e_mdu_pkg.sv | 29 ++
 rtl/e_mdu.sv | 145 ++++++++++++++
 tb/tb_e_mdu.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/e_mdu_pkg.sv
// Shared definitions for the e_mdu multiply/divide unit: operation codes and
// the write-back kinds applied when an operation completes.
package e_mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MFHI  = 4'd7,
    MDU_MFLO  = 4'd8,
    MDU_MADD  = 4'd9,
    MDU_MADDU = 4'd10,
    MDU_MSUB  = 4'd11,
    MDU_MSUBU = 4'd12
  } mdu_op_e;

  // What happens to {hi,lo} on the completing edge.
  typedef enum logic [1:0] {
    WB_WRITE = 2'd0,
    WB_KEEP  = 2'd1,
    WB_ADD   = 2'd2,
    WB_SUB   = 2'd3
  } wb_kind_e;

endpackage

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit holding architectural HI/LO.
// Define MDU_MADD_EN to add the madd/maddu/msub/msubu accumulate operations.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  mdu_op,
  input  logic        start,
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic [31:0] mdu_out
);

  localparam logic [3:0] MUL_CNT = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_CNT = 4'(DIV_CYCLES);

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] temp_q, temp_d;
  wb_kind_e    kind_q, kind_d;

  mdu_op_e     op;
  logic [63:0] prod_s, prod_u;
  logic [31:0] quot_s, rem_s, quot_u, rem_u;

  assign op = mdu_op_e'(mdu_op);

  always_comb begin
    prod_s = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
    prod_u = {32'b0, a} * {32'b0, b};
    quot_s = '0;
    rem_s  = '0;
    quot_u = '0;
    rem_u  = '0;
    if (b != 32'd0) begin
      quot_u = a / b;
      rem_u  = a % b;
      // The one signed quotient that does not fit in 32 bits wraps to itself.
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        quot_s = 32'h8000_0000;
        rem_s  = 32'd0;
      end else begin
        quot_s = 32'($signed(a) / $signed(b));
        rem_s  = 32'($signed(a) % $signed(b));
      end
    end
  end

  always_comb begin
    // NOTE: every next-state value defaults to its current value first, so no path leaves one unassigned and no latch is inferred.
    hi_d   = hi_q;
    lo_d   = lo_q;
    busy_d = busy_q;
    cnt_d  = cnt_q;
    temp_d = temp_q;
    kind_d = kind_q;

    if (busy_q) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        busy_d = 1'b0;
        unique case (kind_q)
          WB_WRITE: {hi_d, lo_d} = temp_q;
`ifdef MDU_MADD_EN
          WB_ADD:   {hi_d, lo_d} = {hi_q, lo_q} + temp_q;
          WB_SUB:   {hi_d, lo_d} = {hi_q, lo_q} - temp_q;
`endif
          default: ;
        endcase
      end
    end else begin
      unique case (op)
        MDU_MTHI: hi_d = a;
        MDU_MTLO: lo_d = a;
        default: ;
      endcase
      if (start) begin
        unique case (op)
          MDU_MULT:  begin temp_d = prod_s; kind_d = WB_WRITE; cnt_d = MUL_CNT; busy_d = 1'b1; end
          MDU_MULTU: begin temp_d = prod_u; kind_d = WB_WRITE; cnt_d = MUL_CNT; busy_d = 1'b1; end
          MDU_DIV: begin
            temp_d = {rem_s, quot_s};
            kind_d = (b == 32'd0) ? WB_KEEP : WB_WRITE;
            cnt_d  = DIV_CNT;
            busy_d = 1'b1;
          end
          MDU_DIVU: begin
            temp_d = {rem_u, quot_u};
            kind_d = (b == 32'd0) ? WB_KEEP : WB_WRITE;
            cnt_d  = DIV_CNT;
            busy_d = 1'b1;
          end
`ifdef MDU_MADD_EN
          MDU_MADD:  begin temp_d = prod_s; kind_d = WB_ADD; cnt_d = MUL_CNT; busy_d = 1'b1; end
          MDU_MADDU: begin temp_d = prod_u; kind_d = WB_ADD; cnt_d = MUL_CNT; busy_d = 1'b1; end
          MDU_MSUB:  begin temp_d = prod_s; kind_d = WB_SUB; cnt_d = MUL_CNT; busy_d = 1'b1; end
          MDU_MSUBU: begin temp_d = prod_u; kind_d = WB_SUB; cnt_d = MUL_CNT; busy_d = 1'b1; end
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
      temp_q <= '0;
      kind_q <= WB_WRITE;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      temp_q <= temp_d;
      kind_q <= kind_d;
    end
  end

  assign busy   = busy_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;

  always_comb begin
    unique case (op)
      MDU_MFHI: mdu_out = hi_q;
      MDU_MFLO: mdu_out = lo_q;
      default:  mdu_out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed and random ops against an arithmetic
// model of HI/LO. Define MDU_MADD_EN to also cover the accumulate operations.
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [3:0]  mdu_op = MDU_NONE;
  logic        start = 1'b0;
  logic        busy;
  logic [31:0] hi_out, lo_out, mdu_out;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  e_mdu #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .mdu_op(mdu_op), .start(start),
    .busy(busy), .hi_out(hi_out), .lo_out(lo_out), .mdu_out(mdu_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    assert (!(start && busy)) else $error("start driven while busy");
  end

  function automatic int latency(input mdu_op_e op);
    return (op == MDU_DIV || op == MDU_DIVU) ? 10 : 5;
  endfunction

  // Reference: HI/LO evolve by plain 64-bit arithmetic on the operand values.
  task automatic model_apply(input mdu_op_e op, input logic [31:0] av, input logic [31:0] bv);
    longint          sa = longint'($signed(av));
    longint          sb = longint'($signed(bv));
    longint unsigned ua = {32'b0, av};
    longint unsigned ub = {32'b0, bv};
    logic [63:0]     acc = {hi_m, lo_m};
    case (op)
      MDU_MULT:  {hi_m, lo_m} = 64'(sa * sb);
      MDU_MULTU: {hi_m, lo_m} = 64'(ua * ub);
      MDU_DIV:   if (bv != 0) begin lo_m = 32'(sa / sb); hi_m = 32'(sa % sb); end
      MDU_DIVU:  if (bv != 0) begin lo_m = 32'(ua / ub); hi_m = 32'(ua % ub); end
`ifdef MDU_MADD_EN
      MDU_MADD:  {hi_m, lo_m} = acc + 64'(sa * sb);
      MDU_MADDU: {hi_m, lo_m} = acc + 64'(ua * ub);
      MDU_MSUB:  {hi_m, lo_m} = acc - 64'(sa * sb);
      MDU_MSUBU: {hi_m, lo_m} = acc - 64'(ua * ub);
`endif
      default: ;
    endcase
  endtask

  // Launch one op and count busy cycles; operands are scrambled right after launch.
  task automatic run_op(input mdu_op_e op, input logic [31:0] av, input logic [31:0] bv,
                        input bit now, output int cycles);
    if (!now) @(negedge clk);
    a = av; b = bv; mdu_op = op; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mdu_op = MDU_NONE; a = $urandom; b = $urandom;
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      cycles++;
    end
    model_apply(op, av, bv);
  endtask

  task automatic write_hl(input mdu_op_e op, input logic [31:0] v);
    @(negedge clk);
    mdu_op = op; a = v;
    @(posedge clk); #1;
    mdu_op = MDU_NONE; a = $urandom;
    if (op == MDU_MTHI) hi_m = v; else lo_m = v;
  endtask

  task automatic op_and_check(input string name, input mdu_op_e op,
                              input logic [31:0] av, input logic [31:0] bv, input bit now);
    int cyc;
    run_op(op, av, bv, now, cyc);
    n_cmp++;
    if (cyc !== latency(op)) begin
      n_err++; $display("FAIL %s busy_cycles a=%h b=%h got %0d want %0d", name, av, bv, cyc, latency(op));
    end
    n_cmp++;
    if (hi_out !== hi_m || lo_out !== lo_m) begin
      n_err++; $display("FAIL %s hi_lo a=%h b=%h got %h_%h want %h_%h", name, av, bv, hi_out, lo_out, hi_m, lo_m);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    mdu_op = MDU_MFHI;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0 || mdu_out !== 32'd0) begin
      n_err++; $display("FAIL reset busy=%b hi=%h lo=%h out=%h want 0", busy, hi_out, lo_out, mdu_out);
    end
    mdu_op = MDU_NONE;
  endtask

  task automatic test_mult();
    mdu_op_e op;
    op_and_check("mult_dir", MDU_MULT, 32'd3, 32'hFFFF_FFFC, 1'b0);
    n_cmp++;
    if (hi_out !== 32'hFFFF_FFFF || lo_out !== 32'hFFFF_FFF4) begin
      n_err++; $display("FAIL mult_const got %h_%h want ffffffff_fffffff4", hi_out, lo_out);
    end
    op_and_check("multu_dir", MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    n_cmp++;
    if (hi_out !== 32'h1 || lo_out !== 32'hFFFF_FFFE) begin
      n_err++; $display("FAIL multu_const got %h_%h want 00000001_fffffffe", hi_out, lo_out);
    end
    for (int i = 0; i < 8; i++) begin
      op = (i % 2 == 0) ? MDU_MULT : MDU_MULTU;
      op_and_check("mult_rand", op, $urandom, $urandom, 1'b0);
    end
  endtask

  task automatic test_div();
    mdu_op_e op;
    logic [31:0] bv;
    op_and_check("div_dir", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    n_cmp++;
    if (hi_out !== 32'hFFFF_FFFF || lo_out !== 32'hFFFF_FFFD) begin
      n_err++; $display("FAIL div_const got %h_%h want ffffffff_fffffffd", hi_out, lo_out);
    end
    op_and_check("divu_dir", MDU_DIVU, 32'd7, 32'd2, 1'b0);
    op_and_check("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    n_cmp++;
    if (hi_out !== 32'd0 || lo_out !== 32'h8000_0000) begin
      n_err++; $display("FAIL div_ovf_const got %h_%h want 00000000_80000000", hi_out, lo_out);
    end
    for (int i = 0; i < 8; i++) begin
      op = (i % 2 == 0) ? MDU_DIV : MDU_DIVU;
      bv = (i < 4) ? 32'($urandom_range(1, 300)) : $urandom;
      if (bv == 0) bv = 32'd5;
      if (i % 3 == 0) bv = -bv;
      op_and_check("div_rand", op, $urandom, bv, 1'b0);
    end
  endtask

  task automatic test_div_zero();
    write_hl(MDU_MTHI, 32'h1234);
    write_hl(MDU_MTLO, 32'hCAFE_F00D);
    op_and_check("div_zero", MDU_DIV, 32'h55, 32'd0, 1'b0);
    op_and_check("divu_zero", MDU_DIVU, $urandom, 32'd0, 1'b0);
    mdu_op = MDU_MFHI; #1;
    n_cmp++;
    if (mdu_out !== 32'h1234) begin
      n_err++; $display("FAIL mfhi got %h want 00001234", mdu_out);
    end
    mdu_op = MDU_MFLO; #1;
    n_cmp++;
    if (mdu_out !== 32'hCAFE_F00D) begin
      n_err++; $display("FAIL mflo got %h want cafef00d", mdu_out);
    end
    mdu_op = MDU_NONE;
  endtask

  // start paired with a non mult/div op must leave everything untouched.
  task automatic test_ignored_start();
    mdu_op_e ops [3] = '{MDU_NONE, MDU_MFHI, MDU_MADDU};
    int seen;
    write_hl(MDU_MTHI, 32'd0);
    write_hl(MDU_MTLO, 32'hFFFF_FFFF);
    foreach (ops[k]) begin
`ifdef MDU_MADD_EN
      if (ops[k] == MDU_MADDU) begin
        op_and_check("maddu_dir", MDU_MADDU, 32'd1, 32'd1, 1'b0);
        n_cmp++;
        if (hi_out !== 32'd1 || lo_out !== 32'd0) begin
          n_err++; $display("FAIL maddu_const got %h_%h want 00000001_00000000", hi_out, lo_out);
        end
        continue;
      end
`endif
      @(negedge clk);
      a = 32'd1; b = 32'd1; mdu_op = ops[k]; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; mdu_op = MDU_NONE;
      seen = 0;
      repeat (6) begin @(negedge clk); if (busy) seen++; end
      n_cmp++;
      if (seen !== 0 || hi_out !== hi_m || lo_out !== lo_m) begin
        n_err++; $display("FAIL ignored_start op=%0d busy_cycles=%0d hi_lo=%h_%h want 0 %h_%h",
                          ops[k], seen, hi_out, lo_out, hi_m, lo_m);
      end
    end
  endtask

  // mthi/mtlo issued while busy must be dropped.
  task automatic test_busy_ignores_mt();
    int cyc;
    @(negedge clk);
    a = 32'd100; b = 32'd7; mdu_op = MDU_DIVU; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mdu_op = MDU_MTHI; a = 32'hDEAD_BEEF;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      mdu_op = (i % 2 == 0) ? MDU_MTLO : MDU_MTHI;
      if (busy && cyc == 8) mdu_op = MDU_NONE;
      if (!busy) break;
      cyc++;
    end
    mdu_op = MDU_NONE;
    model_apply(MDU_DIVU, 32'd100, 32'd7);
    n_cmp++;
    if (cyc !== 10 || hi_out !== hi_m || lo_out !== lo_m) begin
      n_err++; $display("FAIL busy_mt cycles=%0d hi_lo=%h_%h want 10 %h_%h", cyc, hi_out, lo_out, hi_m, lo_m);
    end
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    @(negedge clk);
    a = $urandom; b = $urandom; mdu_op = MDU_MULT; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mdu_op = MDU_NONE;
    for (int i = 0; i < 20 && cyc < 3; i++) begin
      @(negedge clk);
      if (busy) cyc++;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    hi_m = '0; lo_m = '0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
      n_err++; $display("FAIL reset_mid busy=%b hi_lo=%h_%h want 0 0_0", busy, hi_out, lo_out);
    end
    repeat (8) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
      n_err++; $display("FAIL reset_late busy=%b hi_lo=%h_%h want 0 0_0", busy, hi_out, lo_out);
    end
  endtask

  task automatic test_back_to_back();
    mdu_op_e ops [4] = '{MDU_MULT, MDU_DIV, MDU_MULTU, MDU_DIVU};
    op_and_check("b2b_first", MDU_MULTU, $urandom, $urandom, 1'b0);
    for (int i = 0; i < 6; i++)
      op_and_check("b2b", ops[i % 4], $urandom, 32'($urandom_range(1, 1000)), 1'b1);
  endtask

`ifdef MDU_MADD_EN
  task automatic test_madd();
    mdu_op_e ops [4] = '{MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU};
    for (int i = 0; i < 8; i++)
      op_and_check("madd_rand", ops[i % 4], $urandom, $urandom, i[0]);
  endtask
`endif

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_ignored_start();
    test_busy_ignores_mt();
    test_back_to_back();
`ifdef MDU_MADD_EN
    test_madd();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
